// File: rtl/updown_bcd_display.sv
// Multi-digit up/down BCD counter driven by two raw push-buttons.
// Each button is synchronised, debounced and turned into step pulses, with
// optional hold-to-repeat. The count drives a time-multiplexed 7-segment
// display with optional leading-zero blanking.
module updown_bcd_display #(
   parameter int DIGITS        = 4,
   parameter int MAX_VALUE     = 9999,
   parameter int WRAP          = 1,
   parameter int DEB_CYCLES    = 250000,
   parameter int REPEAT_EN     = 1,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   parameter int SCAN_CYCLES   = 50000,
   parameter int LZ_BLANK      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up,
   input  logic                  down,
   output logic [4*DIGITS-1:0]   count,
   output logic                  at_max,
   output logic                  at_min,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int CW   = 4 * DIGITS;
   localparam int DCW  = $clog2(DEB_CYCLES + 2) + 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RTW  = $clog2(RMAX + 1) + 1;
   localparam int SCW  = $clog2(SCAN_CYCLES + 1) + 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Elaboration-time conversion of the limit into packed BCD.
   function automatic logic [CW-1:0] to_bcd(input int value);
      logic [CW-1:0] r;
      int            v;
      r = '0;
      v = value;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v           = v / 10;
      end
      return r;
   endfunction

   localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_VALUE);

   // Ripple BCD increment: a digit at 9 rolls to 0 and carries onward.
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Ripple BCD decrement: a digit at 0 rolls to 9 and borrows onward.
   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (r[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Segment patterns, bit 6 = a down to bit 0 = g.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // Button index 0 = up, 1 = down.
   logic [1:0]     raw;
   logic [1:0]     sync1_q, sync2_q;
   logic [1:0]     lvl_q, lvlp_q;
   logic [1:0]     lock_q, held_q, first_q;
   logic [DCW-1:0] dcnt_q [2];
   logic [DCW-1:0] lcnt_q [2];
   logic [RTW-1:0] rtm_q  [2];
   logic [1:0]     fire, rep, step;

   logic [CW-1:0]  count_q, count_d;
   logic           at_max_q, at_max_d;
   logic           at_min_q, at_min_d;

   logic [SCW-1:0]    scnt_q;
   logic [IW-1:0]     idx_q;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [DIGITS-1:0] lz;
   logic [3:0]        sel_digit;
   logic              sel_blank;
   logic              hz;

   assign raw = {down, up};

   // Step pulses: first step on a debounced rising edge, then hold repeats.
   always_comb begin
      fire = '0;
      rep  = '0;
      for (int b = 0; b < 2; b++) begin
         fire[b] = lvl_q[b] & ~lvlp_q[b] & ~lock_q[b];
         rep[b]  = (REPEAT_EN != 0) && held_q[b] && lvl_q[b] &&
                   (rtm_q[b] == (first_q[b] ? RTW'(REPEAT_DELAY) : RTW'(REPEAT_PERIOD)));
      end
      step = fire | rep;
   end

   // Synchroniser, debouncer, post-reset lockout and repeat timer per button.
   // The lockout keeps a button held through reset from stepping until it has
   // been seen released (debounced low plus the synchroniser flush).
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         lvlp_q  <= '0;
         lock_q  <= '1;
         held_q  <= '0;
         first_q <= '0;
         for (int b = 0; b < 2; b++) begin
            dcnt_q[b] <= '0;
            lcnt_q[b] <= '0;
            rtm_q[b]  <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         lvlp_q  <= lvl_q;
         for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
               if (dcnt_q[b] == DCW'(DEB_CYCLES - 1)) begin
                  lvl_q[b]  <= sync2_q[b];
                  dcnt_q[b] <= '0;
               end else begin
                  dcnt_q[b] <= dcnt_q[b] + DCW'(1);
               end
            end else begin
               dcnt_q[b] <= '0;
            end

            if (lock_q[b] && !sync2_q[b] && !lvl_q[b]) begin
               if (lcnt_q[b] == DCW'(DEB_CYCLES + 1)) begin
                  lock_q[b] <= 1'b0;
                  lcnt_q[b] <= '0;
               end else begin
                  lcnt_q[b] <= lcnt_q[b] + DCW'(1);
               end
            end else begin
               lcnt_q[b] <= '0;
            end

            if (fire[b]) begin
               held_q[b]  <= 1'b1;
               first_q[b] <= 1'b1;
               rtm_q[b]   <= RTW'(1);
            end else if (!lvl_q[b]) begin
               held_q[b]  <= 1'b0;
            end else if (rep[b]) begin
               first_q[b] <= 1'b0;
               rtm_q[b]   <= RTW'(1);
            end else if (held_q[b]) begin
               rtm_q[b]   <= rtm_q[b] + RTW'(1);
            end
         end
      end
   end

   // Next count: opposing steps cancel; limits wrap or saturate.
   always_comb begin
      count_d = count_q;
      if (step[0] && !step[1]) begin
         if (count_q == MAX_BCD) begin
            count_d = (WRAP != 0) ? '0 : count_q;
         end else begin
            count_d = bcd_inc(count_q);
         end
      end else if (step[1] && !step[0]) begin
         if (count_q == '0) begin
            count_d = (WRAP != 0) ? MAX_BCD : count_q;
         end else begin
            count_d = bcd_dec(count_q);
         end
      end
      at_max_d = (count_d == MAX_BCD);
      at_min_d = (count_d == '0);
   end

   // Count register with its limit flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         at_max_q <= (MAX_VALUE == 0);
         at_min_q <= 1'b1;
      end else begin
         count_q  <= count_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
      end
   end

   // Scan timer: each digit index is held for SCAN_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt_q <= '0;
         idx_q  <= '0;
      end else if (scnt_q == SCW'(SCAN_CYCLES - 1)) begin
         scnt_q <= '0;
         idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
         scnt_q <= scnt_q + SCW'(1);
      end
   end

   // Digit select, leading-zero detection and segment decode.
   always_comb begin
      lz        = '0;
      hz        = 1'b1;
      sel_digit = 4'd0;
      sel_blank = 1'b0;
      an_d      = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hz    = hz & (count_q[4*i +: 4] == 4'd0);
         lz[i] = hz;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            an_d[i]   = 1'b1;
            sel_digit = count_q[4*i +: 4];
            sel_blank = (LZ_BLANK != 0) && (i != 0) && lz[i];
         end
      end
      seg_d = sel_blank ? 7'b0000000 : seg_decode(sel_digit);
   end

   // Registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '0;
         an_q  <= '0;
      end else begin
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign count  = count_q;
   assign at_max = at_max_q;
   assign at_min = at_min_q;
   assign seg    = seg_q;
   assign an     = an_q;

endmodule
